// File: rtl/ahb_mem_pkg.sv
// ahb_mem_pkg: AHB-Lite encodings, slave FSM states and the byte-lane strobe helper
// shared by ahb_mem_slave and its bench.
package ahb_mem_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  localparam logic [2:0] HSIZE_BYTE  = 3'b000;
  localparam logic [2:0] HSIZE_HALF  = 3'b001;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;
  localparam logic [2:0] HSIZE_DWORD = 3'b011;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  localparam int unsigned MAX_STRB = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ERR1,
    S_ERR2
  } state_t;

  // Strobe for the widest bus; callers keep the low DATA_WIDTH/8 bits.
  function automatic logic [MAX_STRB-1:0] byte_strobe(input logic [2:0] size,
                                                      input logic [2:0] lane);
    logic [15:0] ones;
    ones = (16'd1 << (16'd1 << size)) - 16'd1;
    return MAX_STRB'(ones << lane);
  endfunction

endpackage

// File: rtl/ahb_mem_bytelane_ram.sv
// ahb_mem_bytelane_ram: word-wide RAM with per-byte write enables and asynchronous read.
module ahb_mem_bytelane_ram #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned IDX_W      = 4
) (
  input  logic                    clk,
  input  logic [DATA_WIDTH/8-1:0] we,
  input  logic [IDX_W-1:0]        addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH-1:0]   rdata
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int unsigned b = 0; b < BYTES; b++) begin
      if (we[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/ahb_mem_slave.sv
// ahb_mem_slave: AHB-Lite memory slave with wait states, byte-lane writes and two-cycle ERROR.
// Define AHB_MEM_SLAVE_BURST_CHECK_EN to check SEQ beats against the expected burst address.
module ahb_mem_slave
  import ahb_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned MEM_DEPTH    = 16,
  parameter int unsigned WAIT_STATES  = 0,
  parameter int unsigned NO_OF_SLAVES = 4
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic [1:0]            HRESP,
  output logic [DATA_WIDTH-1:0] HRDATA
);

  localparam int unsigned BYTES  = DATA_WIDTH / 8;
  localparam int unsigned LANE_W = $clog2(BYTES);
  localparam int unsigned DEC_W  = $clog2(NO_OF_SLAVES);
  localparam int unsigned OFF_W  = ADDR_WIDTH - DEC_W;
  localparam int unsigned IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  state_t                state, state_nx;
  logic [3:0]            wcnt, wcnt_nx;
  logic                  pend, pend_nx;
  logic [IDX_W-1:0]      idx_r;
  logic [LANE_W-1:0]     lane_r;
  logic [2:0]            size_r;
  logic                  write_r;
  logic [DATA_WIDTH-1:0] rdata_q, mem_rdata;
  logic [OFF_W-1:0]      off, word_idx;
  logic [7:0]            align_mask;
  logic [MAX_STRB-1:0]   strb_all;
  logic                  addr_err, seq_err, take, ready_st, done, rd_cmp, wr_cmp;
  logic                  unused_bits;

  assign off        = HADDR[OFF_W-1:0];
  assign word_idx   = off >> LANE_W;
  assign align_mask = (8'd1 << HSIZE) - 8'd1;
  assign addr_err   = (word_idx >= OFF_W'(MEM_DEPTH)) || (32'(HSIZE) > LANE_W)
                   || ((8'(off) & align_mask) != 8'd0);
  assign ready_st   = (state == S_IDLE) || (state == S_ERR2);
  assign take       = HSEL && HREADY && HTRANS[1] && ready_st;

`ifdef AHB_MEM_SLAVE_BURST_CHECK_EN
  logic             exp_vld, exp_write;
  logic [OFF_W-1:0] exp_off, nxt_off, step, wrap_mask;
  logic [2:0]       exp_size, burst_r, burst_eff;

  // The burst type is only presented on NONSEQ; later beats use the stored copy.
  assign burst_eff = (HTRANS == HTRANS_NONSEQ) ? HBURST : burst_r;
  assign step      = OFF_W'(1) << HSIZE;

  always_comb begin
    wrap_mask = '1;
    case (burst_eff)
      HBURST_WRAP4:  wrap_mask = (step << 2) - OFF_W'(1);
      HBURST_WRAP8:  wrap_mask = (step << 3) - OFF_W'(1);
      HBURST_WRAP16: wrap_mask = (step << 4) - OFF_W'(1);
      default:       wrap_mask = '1;
    endcase
  end

  assign nxt_off = (off & ~wrap_mask) | ((off + step) & wrap_mask);
  assign seq_err = (HTRANS == HTRANS_SEQ)
                && (!exp_vld || off != exp_off || HSIZE != exp_size || HWRITE != exp_write);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      exp_vld   <= 1'b0;
      exp_off   <= '0;
      exp_size  <= '0;
      exp_write <= 1'b0;
      burst_r   <= HBURST_SINGLE;
    end else if (take) begin
      exp_vld   <= 1'b1;
      exp_off   <= nxt_off;
      exp_size  <= HSIZE;
      exp_write <= HWRITE;
      if (HTRANS == HTRANS_NONSEQ) burst_r <= HBURST;
    end else if (HREADY && (!HSEL || HTRANS == HTRANS_IDLE)) begin
      exp_vld <= 1'b0;
    end
  end
`else
  assign seq_err = 1'b0;
`endif

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state <= S_IDLE;
      wcnt  <= '0;
      pend  <= 1'b0;
    end else begin
      state <= state_nx;
      wcnt  <= wcnt_nx;
      pend  <= pend_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    wcnt_nx   = wcnt;
    pend_nx   = pend;
    HREADYOUT = ready_st;
    HRESP     = HRESP_OKAY;
    unique case (state)
      S_IDLE, S_ERR2: begin
        if (state == S_ERR2) HRESP = HRESP_ERROR;
        state_nx = S_IDLE;
        pend_nx  = 1'b0;
        if (take) begin
          if (addr_err || seq_err) begin
            state_nx = S_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_nx = S_WAIT;
            wcnt_nx  = 4'(WAIT_STATES - 1);
            pend_nx  = 1'b1;
          end else begin
            pend_nx = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (wcnt == 4'd0) state_nx = S_IDLE;
        else              wcnt_nx  = wcnt - 4'd1;
      end
      S_ERR1: begin
        HRESP    = HRESP_ERROR;
        state_nx = S_ERR2;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      idx_r   <= '0;
      lane_r  <= '0;
      size_r  <= HSIZE_BYTE;
      write_r <= 1'b0;
    end else if (take) begin
      idx_r   <= IDX_W'(word_idx);
      lane_r  <= off[LANE_W-1:0];
      size_r  <= HSIZE;
      write_r <= HWRITE;
    end
  end

  // A pending OKAY transfer completes in the first IDLE cycle after its wait states.
  assign done     = pend && (state == S_IDLE);
  assign wr_cmp   = done && write_r;
  assign rd_cmp   = done && !write_r;
  assign strb_all = byte_strobe(size_r, 3'(lane_r));

  ahb_mem_bytelane_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (MEM_DEPTH),
    .IDX_W      (IDX_W)
  ) u_ram (
    .clk   (HCLK),
    .we    (strb_all[BYTES-1:0] & {BYTES{wr_cmp}}),
    .addr  (idx_r),
    .wdata (HWDATA),
    .rdata (mem_rdata)
  );

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)    rdata_q <= '0;
    else if (rd_cmp) rdata_q <= mem_rdata;
  end

  assign HRDATA      = rd_cmp ? mem_rdata : rdata_q;
  assign unused_bits = ^{HADDR, HBURST, strb_all};

endmodule

// File: tb/tb_ahb_mem_slave.sv
// tb_ahb_mem_slave: two ahb_mem_slave instances (0 and 3 wait states) driven with directed and
// random pipelined transfers, checked cycle by cycle against a byte-array reference model.
module tb_ahb_mem_slave;
  import ahb_mem_pkg::*;

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic        write;
    logic [2:0]  size;
    logic [2:0]  burst;
    logic [31:0] addr;
    logic [31:0] wdata;
  } xfer_t;

  typedef struct {
    bit          act;
    bit          err;
    bit          write;
    int unsigned size;
    int unsigned off;
    logic [31:0] wdata;
    int unsigned cyc;
  } dp_t;

  logic clk = 1'b0;
  logic hresetn = 1'b1;
  always #5 clk = ~clk;

  logic        hsel      [2];
  logic [31:0] haddr     [2];
  logic [1:0]  htrans    [2];
  logic        hwrite    [2];
  logic [2:0]  hsize     [2];
  logic [2:0]  hburst    [2];
  logic [31:0] hwdata    [2];
  logic        hreadyout [2];
  logic [1:0]  hresp     [2];
  logic [31:0] hrdata    [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    ahb_mem_slave #(
      .ADDR_WIDTH   (32),
      .DATA_WIDTH   (32),
      .MEM_DEPTH    (16),
      .WAIT_STATES  ((g == 0) ? 0 : 3),
      .NO_OF_SLAVES (4)
    ) u_dut (
      .HCLK      (clk),
      .HRESETn   (hresetn),
      .HSEL      (hsel[g]),
      .HADDR     (haddr[g]),
      .HTRANS    (htrans[g]),
      .HWRITE    (hwrite[g]),
      .HSIZE     (hsize[g]),
      .HBURST    (hburst[g]),
      .HWDATA    (hwdata[g]),
      .HREADY    (hreadyout[g]),
      .HREADYOUT (hreadyout[g]),
      .HRESP     (hresp[g]),
      .HRDATA    (hrdata[g])
    );
  end

  // Reference model: byte-addressed memory, last read word, burst expectation.
  logic [7:0]  mb      [2][64];
  logic [31:0] last_rd [2];
`ifdef AHB_MEM_SLAVE_BURST_CHECK_EN
  bit          ev [2];
  int unsigned eo [2];
  int unsigned es [2];
  bit          ew [2];
  logic [2:0]  eb [2];
`endif

  int n_vec = 0;
  int n_err = 0;
  xfer_t q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int unsigned ws_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  function automatic logic [31:0] model_word(input int d, input int unsigned idx);
    return {mb[d][idx*4+3], mb[d][idx*4+2], mb[d][idx*4+1], mb[d][idx*4]};
  endfunction

`ifdef AHB_MEM_SLAVE_BURST_CHECK_EN
  function automatic int unsigned next_off(input int unsigned off, input int unsigned step,
                                           input logic [2:0] burst);
    int unsigned beats, bnd, base;
    beats = (burst == HBURST_WRAP4) ? 4 : (burst == HBURST_WRAP8) ? 8 :
            (burst == HBURST_WRAP16) ? 16 : 0;
    if (beats == 0) return (off + step) & 32'h3FFF_FFFF;
    bnd  = beats * step;
    base = off - (off % bnd);
    return base + ((off - base + step) % bnd);
  endfunction
`endif

  task automatic push(input logic sel, input logic [1:0] trans, input logic write,
                      input logic [2:0] size, input logic [2:0] burst,
                      input logic [31:0] addr, input logic [31:0] wdata);
    xfer_t x;
    x.sel = sel; x.trans = trans; x.write = write; x.size = size;
    x.burst = burst; x.addr = addr; x.wdata = wdata;
    q.push_back(x);
  endtask

  task automatic put(input int d, input xfer_t x);
    hsel[d]   = x.sel;
    htrans[d] = x.trans;
    hwrite[d] = x.write;
    hsize[d]  = x.size;
    hburst[d] = x.burst;
    haddr[d]  = x.addr;
  endtask

  // Address phase seen by the slave at an edge where the bus is ready.
  task automatic bus_edge(input int d, input xfer_t x, output dp_t dp);
    int unsigned off, step;
    off       = 32'(x.addr[29:0]);
    step      = 1 << x.size;
    dp.act    = 1'b0;
    dp.err    = 1'b0;
    dp.write  = x.write;
    dp.size   = 32'(x.size);
    dp.off    = off;
    dp.wdata  = x.wdata;
    dp.cyc    = 0;
    if (x.sel && x.trans[1]) begin
      dp.act = 1'b1;
      dp.err = (off / 4 >= 16) || (x.size > 3'd2) || (off % step != 0);
`ifdef AHB_MEM_SLAVE_BURST_CHECK_EN
      if (x.trans == HTRANS_SEQ &&
          (!ev[d] || off != eo[d] || 32'(x.size) != es[d] || x.write != ew[d])) dp.err = 1'b1;
      if (x.trans == HTRANS_NONSEQ) eb[d] = x.burst;
      ev[d] = 1'b1;
      eo[d] = next_off(off, step, eb[d]);
      es[d] = 32'(x.size);
      ew[d] = x.write;
`endif
    end
`ifdef AHB_MEM_SLAVE_BURST_CHECK_EN
    else if (!x.sel || x.trans == HTRANS_IDLE) ev[d] = 1'b0;
`endif
  endtask

  task automatic check_cycle(input int d, input dp_t dp, input logic ro, input logic [1:0] rs,
                             input logic [31:0] rd);
    logic er;
    logic [1:0] ers;
    logic [31:0] erd;
    erd = last_rd[d];
    ers = HRESP_OKAY;
    if (!dp.act) begin
      er = 1'b1;
    end else if (dp.err) begin
      er  = (dp.cyc >= 1);
      ers = HRESP_ERROR;
    end else begin
      er = (dp.cyc >= ws_of(d));
      if (er && !dp.write) erd = model_word(d, dp.off / 4);
    end
    check($sformatf("d%0d hreadyout off=%0h cyc=%0d", d, dp.off, dp.cyc), 64'(ro), 64'(er));
    check($sformatf("d%0d hresp off=%0h cyc=%0d", d, dp.off, dp.cyc), 64'(rs), 64'(ers));
    check($sformatf("d%0d hrdata off=%0h cyc=%0d", d, dp.off, dp.cyc), 64'(rd), 64'(erd));
  endtask

  // Drive the queued transfers pipelined onto slave d, checking every data-phase cycle.
  task automatic run(input int d);
    xfer_t idle_x, cur;
    dp_t dp, nx;
    int unsigned k, n, budget, lane;
    logic ro;
    logic [1:0] rs;
    logic [31:0] rd;
    idle_x = '{sel: 1'b0, trans: HTRANS_IDLE, write: 1'b0, size: HSIZE_WORD,
               burst: HBURST_SINGLE, addr: 32'h0, wdata: 32'h0};
    n = q.size();
    k = 0;
    budget = 40 * n + 40;
    dp.act = 1'b0; dp.err = 1'b0; dp.write = 1'b0; dp.size = 0; dp.off = 0;
    dp.wdata = '0; dp.cyc = 0;
    cur = (n > 0) ? q[0] : idle_x;
    put(d, cur);
    while ((k < n || dp.act) && budget > 0) begin
      budget--;
      @(negedge clk);
      ro = hreadyout[d];
      rs = hresp[d];
      rd = hrdata[d];
      check_cycle(d, dp, ro, rs, rd);
      @(posedge clk);
      #1;
      if (ro) begin
        if (dp.act && !dp.err) begin
          lane = dp.off % 4;
          if (dp.write) begin
            for (int unsigned b = 0; b < (1 << dp.size); b++)
              mb[d][(dp.off / 4) * 4 + lane + b] = dp.wdata[(lane + b) * 8 +: 8];
          end else begin
            last_rd[d] = model_word(d, dp.off / 4);
          end
        end
        bus_edge(d, cur, nx);
        dp = nx;
        if (k < n) k++;
        cur = (k < n) ? q[k] : idle_x;
        put(d, cur);
        hwdata[d] = dp.act ? dp.wdata : $urandom;
      end else begin
        dp.cyc++;
      end
    end
    if (budget == 0) check($sformatf("d%0d run timeout", d), 64'(0), 64'(1));
    @(posedge clk);
    #1;
`ifdef AHB_MEM_SLAVE_BURST_CHECK_EN
    ev[d] = 1'b0;
`endif
    q.delete();
  endtask

  task automatic gen_random(input int unsigned n);
    logic [2:0] sz;
    logic [31:0] a, base;
    logic wr;
    int unsigned r, lane;
    for (int unsigned i = 0; i < n; i++) begin
      r  = $urandom_range(0, 11);
      sz = (r == 0) ? HSIZE_DWORD : 3'($urandom_range(0, 2));
      lane = ($urandom_range(0, 3) >> sz) << sz;
      if ($urandom_range(0, 9) == 0) lane = $urandom_range(0, 3);
      a  = {2'($urandom), 30'($urandom_range(0, 19) * 4 + lane)};
      wr = 1'($urandom);
      if (r <= 6)       push(1'b1, HTRANS_NONSEQ, wr, sz, HBURST_SINGLE, a, $urandom);
      else if (r == 7)  push(1'b1, HTRANS_IDLE, wr, sz, HBURST_SINGLE, a, $urandom);
      else if (r == 8)  push(1'b0, HTRANS_NONSEQ, wr, sz, HBURST_SINGLE, a, $urandom);
      else if (r == 9)  push(1'b1, HTRANS_SEQ, wr, sz, HBURST_INCR, a, $urandom);
      else begin
        base = 32'($urandom_range(0, 15) * 4);
        for (int unsigned b = 0; b < 4; b++) begin
          a = (r == 10) ? ((base & ~32'hF) | ((base + b * 4) & 32'hF)) : (base + b * 4);
          if (b > 0 && $urandom_range(0, 3) == 0)
            push(1'b1, HTRANS_BUSY, wr, HSIZE_WORD, HBURST_INCR4, a, $urandom);
          if ($urandom_range(0, 15) == 0) a = a + 4;
          push(1'b1, (b == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, wr, HSIZE_WORD,
               (r == 10) ? HBURST_WRAP4 : HBURST_INCR4, a, $urandom);
        end
      end
    end
  endtask

  task automatic do_reset();
    hresetn = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("d%0d reset hreadyout", d), 64'(hreadyout[d]), 64'(1));
      check($sformatf("d%0d reset hresp", d), 64'(hresp[d]), 64'(HRESP_OKAY));
      check($sformatf("d%0d reset hrdata", d), 64'(hrdata[d]), 64'(0));
      last_rd[d] = '0;
`ifdef AHB_MEM_SLAVE_BURST_CHECK_EN
      ev[d] = 1'b0;
`endif
    end
    @(posedge clk);
    @(negedge clk);
    hresetn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      hsel[d] = 1'b0; htrans[d] = HTRANS_IDLE; hwrite[d] = 1'b0; hsize[d] = HSIZE_WORD;
      hburst[d] = HBURST_SINGLE; haddr[d] = '0; hwdata[d] = '0;
    end
    #2;
    do_reset();

    for (int d = 0; d < 2; d++) begin
      for (int unsigned w = 0; w < 16; w++)
        push(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, HBURST_SINGLE, 32'(w * 4), $urandom);
      run(d);
    end

    for (int d = 0; d < 2; d++) begin
      push(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, HBURST_SINGLE, 32'h8, 32'hDEADBEEF);
      push(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, HBURST_SINGLE, 32'h8, 32'h0);
      push(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, HBURST_SINGLE, 32'h4, 32'h0);
      push(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, HBURST_SINGLE, 32'h0, 32'h11223344);
      push(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_BYTE, HBURST_SINGLE, 32'h2, 32'h00AA0000);
      push(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, HBURST_SINGLE, 32'h0, 32'h0);
      push(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, HBURST_SINGLE, 32'h40, 32'h55555555);
      push(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, HBURST_SINGLE, 32'h40, 32'h0);
      push(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, HBURST_SINGLE, 32'h3C, 32'h0);
      push(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_HALF, HBURST_SINGLE, 32'h1, 32'hFFFFFFFF);
      push(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_DWORD, HBURST_SINGLE, 32'h0, 32'h0);
      push(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, HBURST_SINGLE, 32'h8, 32'h0);
      push(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_HALF, HBURST_SINGLE, 32'h6, 32'h7E7E0000);
      push(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, HBURST_SINGLE, 32'h4, 32'h0);
      for (int unsigned b = 0; b < 4; b++)
        push(1'b1, (b == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, 1'b1, HSIZE_WORD, HBURST_INCR4,
             32'(b * 4), 32'hA0A0_0000 + 32'(b));
      push(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, HBURST_SINGLE, 32'h20, 32'h600DF00D);
      push(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, HBURST_SINGLE, 32'h20, 32'h0);
      push(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, HBURST_WRAP4, 32'h8, 32'h0);
      push(1'b1, HTRANS_SEQ, 1'b0, HSIZE_WORD, HBURST_WRAP4, 32'hC, 32'h0);
      push(1'b1, HTRANS_SEQ, 1'b0, HSIZE_WORD, HBURST_WRAP4, 32'h10, 32'h0);
      push(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, HBURST_INCR4, 32'h30, 32'h13579BDF);
      push(1'b1, HTRANS_BUSY, 1'b1, HSIZE_WORD, HBURST_INCR4, 32'h34, 32'h0);
      push(1'b1, HTRANS_SEQ, 1'b1, HSIZE_WORD, HBURST_INCR4, 32'h34, 32'h2468ACE0);
      push(1'b1, HTRANS_SEQ, 1'b0, HSIZE_WORD, HBURST_INCR, 32'h0, 32'h0);
      run(d);
    end

    // Reset while a write to 0x10 is in its wait states: the write must be dropped.
    hsel[1] = 1'b1; htrans[1] = HTRANS_NONSEQ; hwrite[1] = 1'b1;
    hsize[1] = HSIZE_WORD; haddr[1] = 32'h10;
    @(posedge clk);
    #1;
    hsel[1] = 1'b0; htrans[1] = HTRANS_IDLE; hwdata[1] = 32'hCAFEF00D;
    @(negedge clk);
    check("d1 wait before reset", 64'(hreadyout[1]), 64'(0));
    do_reset();
    for (int d = 0; d < 2; d++) begin
      push(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, HBURST_SINGLE, 32'h10, 32'h0);
      run(d);
    end

    for (int r = 0; r < 2; r++) begin
      for (int d = 0; d < 2; d++) begin
        gen_random(150);
        run(d);
      end
    end

    for (int d = 0; d < 2; d++) begin
      for (int unsigned w = 0; w < 16; w++)
        push(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, HBURST_SINGLE, 32'(w * 4), 32'h0);
      run(d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
